// File: rtl/rmt_pkg.sv
// rmt_pkg: widths shared across match-action stages and the stage link buffer.
//   PHV_LEN              PHV width in bits (32 containers x 64 + 256)
//   C_VLANID_WIDTH       VLAN id width
//   C_S_AXIS_DATA_WIDTH  control-path AXIS data width
//   C_S_AXIS_TUSER_WIDTH control-path AXIS tuser width
//   clog2()              pointer width helper, never returns less than 1
package rmt_pkg;

    localparam int unsigned C_S_AXIS_DATA_WIDTH  = 256;
    localparam int unsigned C_S_AXIS_TUSER_WIDTH = 128;
    localparam int unsigned PHV_LEN              = 32 * 64 + 256;
    localparam int unsigned C_VLANID_WIDTH       = 12;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/link_fifo.sv
// link_fifo: show-ahead FIFO with a registered input ready.
//   axis_clk    clock
//   aresetn     asynchronous active-low reset
//   in_data     push data
//   in_valid    push request
//   in_ready    registered (count < DEPTH); low during reset, high the cycle after release
//   out_data    head entry (zero while empty)
//   out_valid   FIFO not empty
//   out_ready   pop request
//   level_next  occupancy after the coming edge
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module link_fifo
    import rmt_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   axis_clk,
    input  logic                   aresetn,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [clog2(DEPTH):0]  level_next
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    // ready_q is only ever high when count_q < DEPTH, so it alone gates the push
    assign push      = in_valid && ready_q;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        // Registered from next occupancy: a pop at full reopens ready one cycle later
        ready_d = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset: the head is masked while empty
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready   = ready_q;
    assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
    assign level_next = count_d;

endmodule

// File: rtl/stage_link_buffer.sv
// stage_link_buffer: elastic buffer between match-action stage N and stage N+1.
//   axis_clk, aresetn               clock, asynchronous active-low reset
//   phv_in/_valid/_ready            PHV from upstream (ready is registered)
//   vlan_in/_valid/_ready           VLAN id from upstream (ready is registered)
//   phv_out/_valid/_ready           head PHV to downstream
//   vlan_out/_valid/_ready          head VLAN id to downstream
//   c_s_axis_t*                     control-path AXIS in
//   c_m_axis_t*                     control-path AXIS out, one register slice, never stalls
// Optional macro STAGE_LINK_BUF_STATS_EN adds:
//   stat_phv_hwm                    max PHV occupancy since reset
//   stat_phv_stall                  saturating count of cycles phv_in_valid && !phv_in_ready
module stage_link_buffer
    import rmt_pkg::clog2;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = rmt_pkg::C_S_AXIS_DATA_WIDTH,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = rmt_pkg::C_S_AXIS_TUSER_WIDTH,
    parameter int unsigned PHV_LEN              = rmt_pkg::PHV_LEN,
    parameter int unsigned C_VLANID_WIDTH       = rmt_pkg::C_VLANID_WIDTH,
    parameter int unsigned PHV_DEPTH            = 4,
    parameter int unsigned VLAN_DEPTH           = 8
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,

    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic                              phv_in_valid,
    output logic                              phv_in_ready,
    input  logic [C_VLANID_WIDTH-1:0]         vlan_in,
    input  logic                              vlan_in_valid,
    output logic                              vlan_in_ready,

    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_out_valid,
    input  logic                              phv_out_ready,
    output logic [C_VLANID_WIDTH-1:0]         vlan_out,
    output logic                              vlan_out_valid,
    input  logic                              vlan_out_ready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast
`ifdef STAGE_LINK_BUF_STATS_EN
    ,
    output logic [clog2(PHV_DEPTH):0]         stat_phv_hwm,
    output logic [31:0]                       stat_phv_stall
`endif
);

    logic [clog2(PHV_DEPTH):0]  phv_level_next;
    logic [clog2(VLAN_DEPTH):0] vlan_level_next;

    link_fifo #(
        .WIDTH (PHV_LEN),
        .DEPTH (PHV_DEPTH)
    ) u_phv_fifo (
        .axis_clk   (axis_clk),
        .aresetn    (aresetn),
        .in_data    (phv_in),
        .in_valid   (phv_in_valid),
        .in_ready   (phv_in_ready),
        .out_data   (phv_out),
        .out_valid  (phv_out_valid),
        .out_ready  (phv_out_ready),
        .level_next (phv_level_next)
    );

    link_fifo #(
        .WIDTH (C_VLANID_WIDTH),
        .DEPTH (VLAN_DEPTH)
    ) u_vlan_fifo (
        .axis_clk   (axis_clk),
        .aresetn    (aresetn),
        .in_data    (vlan_in),
        .in_valid   (vlan_in_valid),
        .in_ready   (vlan_in_ready),
        .out_data   (vlan_out),
        .out_valid  (vlan_out_valid),
        .out_ready  (vlan_out_ready),
        .level_next (vlan_level_next)
    );

    // Control-path register slice: no backpressure exists on this channel
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end else begin
            c_m_axis_tdata  <= c_s_axis_tdata;
            c_m_axis_tuser  <= c_s_axis_tuser;
            c_m_axis_tkeep  <= c_s_axis_tkeep;
            c_m_axis_tvalid <= c_s_axis_tvalid;
            c_m_axis_tlast  <= c_s_axis_tlast;
        end
    end

`ifdef STAGE_LINK_BUF_STATS_EN
    logic [clog2(PHV_DEPTH):0] hwm_q;
    logic [31:0]               stall_q;

    // Tracking next occupancy keeps the mark current in the same cycle the level is reached
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            hwm_q   <= '0;
            stall_q <= '0;
        end else begin
            if (phv_level_next > hwm_q) begin
                hwm_q <= phv_level_next;
            end
            if (phv_in_valid && !phv_in_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign stat_phv_hwm   = hwm_q;
    assign stat_phv_stall = stall_q;

    logic unused_level;
    assign unused_level = ^vlan_level_next;
`else
    logic unused_level;
    assign unused_level = ^{phv_level_next, vlan_level_next};
`endif

endmodule
